// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: grants one of two byte requesters access to a single UART transmitter,
// with a WAIT-state watchdog. Define ARB_ROUND_ROBIN_EN for round-robin ties; otherwise requester 0 wins.
module uart_tx_arbiter #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic [7:0] data0,
    input  logic       req1,
    input  logic [7:0] data1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       done0,
    output logic       done1,
    output logic       tx_en,
    output logic [7:0] tx_data,
    input  logic       tx_done,
    output logic       busy,
    output logic       timeout_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [1:0]  gnt_q, gnt_d;          // one-hot {gnt1, gnt0}
    logic [7:0]  tx_data_q, tx_data_d;
    logic [15:0] wd_q, wd_d;
    logic        terr_q, terr_d;
    logic        pick1;
    logic [15:0] wd_inc;
    logic        wd_hit;
`ifdef ARB_ROUND_ROBIN_EN
    logic        last_q, last_d;        // 1 = requester 1 was served last
`endif

    always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
        pick1 = req1 && (!req0 || !last_q);
`else
        pick1 = req1 && !req0;
`endif
    end

    assign wd_inc = (wd_q == 16'hFFFF) ? wd_q : wd_q + 16'd1;
    // Testing the incremented value puts DONE exactly TIMEOUT_CYCLES cycles after tx_en.
    assign wd_hit = (wd_inc >= TIMEOUT_CYCLES - 16'd1);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d   = state_q;
        gnt_d     = gnt_q;
        tx_data_d = tx_data_q;
        wd_d      = wd_q;
        terr_d    = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        last_d    = last_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    state_d   = S_START;
                    gnt_d     = pick1 ? 2'b10 : 2'b01;
                    tx_data_d = pick1 ? data1 : data0;
`ifdef ARB_ROUND_ROBIN_EN
                    last_d    = pick1;
`endif
                end
            end
            S_START: begin
                state_d = S_WAIT;
                wd_d    = 16'd0;
            end
            S_WAIT: begin
                wd_d = wd_inc;
                if (tx_done) begin
                    state_d = S_DONE;
                end else if (wd_hit) begin
                    state_d = S_DONE;
                    terr_d  = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                gnt_d   = 2'b00;
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = 2'b00;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            gnt_q     <= 2'b00;
            tx_data_q <= 8'h00;
            wd_q      <= 16'd0;
            terr_q    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_q    <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            tx_data_q <= tx_data_d;
            wd_q      <= wd_d;
            terr_q    <= terr_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_q    <= last_d;
`endif
        end
    end

    assign gnt0        = gnt_q[0];
    assign gnt1        = gnt_q[1];
    assign done0       = (state_q == S_DONE) && gnt_q[0];
    assign done1       = (state_q == S_DONE) && gnt_q[1];
    assign tx_en       = (state_q == S_START);
    assign tx_data     = tx_data_q;
    assign busy        = (state_q != S_IDLE);
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: default-timeout instance plus a TIMEOUT_CYCLES=8 instance
// sharing the same inputs. Inputs change 1ns after posedge; outputs are sampled on negedge.
module tb_uart_tx_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1, tx_done;
    logic [7:0] data0, data1;

    logic       gnt0, gnt1, done0, done1, tx_en, busy, timeout_err;
    logic [7:0] tx_data;
    logic       w_gnt0, w_gnt1, w_done0, w_done1, w_tx_en, w_busy, w_timeout_err;
    logic [7:0] w_tx_data;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter dut (
        .clk(clk), .reset(reset),
        .req0(req0), .data0(data0), .req1(req1), .data1(data1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .tx_en(tx_en), .tx_data(tx_data), .tx_done(tx_done),
        .busy(busy), .timeout_err(timeout_err)
    );

    uart_tx_arbiter #(.TIMEOUT_CYCLES(16'd8)) dut_wd (
        .clk(clk), .reset(reset),
        .req0(req0), .data0(data0), .req1(req1), .data1(data1),
        .gnt0(w_gnt0), .gnt1(w_gnt1), .done0(w_done0), .done1(w_done1),
        .tx_en(w_tx_en), .tx_data(w_tx_data), .tx_done(tx_done),
        .busy(w_busy), .timeout_err(w_timeout_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        req0 = 1'b0; req1 = 1'b0; data0 = 8'h00; data1 = 8'h00; tx_done = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    // Counts negedges from the cycle the request was driven in (that cycle counts as 1).
    task automatic wait_en(input bit wd, input string tag, output int n);
        bit seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            seen = wd ? w_tx_en : tx_en;
        end
        check({tag, "_seen"}, 32'(seen), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_time_limit: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int  n;
        int  done_at, err_at, done_cnt, err_cnt;
        bit  any_done;
        logic exp_order [4];
        logic [7:0] exp_data;

`ifdef ARB_ROUND_ROBIN_EN
        exp_order[0] = 1'b0; exp_order[1] = 1'b1; exp_order[2] = 1'b0; exp_order[3] = 1'b1;
`else
        exp_order[0] = 1'b0; exp_order[1] = 1'b0; exp_order[2] = 1'b0; exp_order[3] = 1'b0;
`endif

        // Reset state of both instances
        reset = 1'b0;
        req0 = 1'b1; req1 = 1'b1; data0 = 8'hEE; data1 = 8'hDD; tx_done = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_ctrl", 32'({gnt0, gnt1, done0, done1, tx_en, busy, timeout_err}), 32'd0);
        check("rst_data", 32'(tx_data), 32'h00);
        check("rst_wd_ctrl", 32'({w_gnt0, w_gnt1, w_done0, w_done1, w_tx_en, w_busy, w_timeout_err}), 32'd0);

        // tx_done while IDLE with no request is ignored
        apply_reset();
        tx_done = 1'b1;
        @(posedge clk); #1 tx_done = 1'b0;
        @(negedge clk);
        check("idle_txdone_busy", 32'(busy), 32'd0);
        check("idle_txdone_done", 32'({done0, done1}), 32'd0);

        // Single request 0, byte A5, tx_done 10 cycles after tx_en
        apply_reset();
        req0 = 1'b1; data0 = 8'hA5;
        wait_en(1'b0, "single", n);
        check("single_latency", 32'(n), 32'd2);
        check("single_data", 32'(tx_data), 32'hA5);
        check("single_gnt", 32'({gnt1, gnt0}), 32'b01);
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1 tx_done = (i == 10);
            @(negedge clk);
            check($sformatf("single_hold_%0d", i), 32'({gnt0, done0, tx_en}), 32'b100);
        end
        @(posedge clk); #1 tx_done = 1'b0; req0 = 1'b0;
        @(negedge clk);
        check("single_done0", 32'({done0, gnt0, done1}), 32'b110);
        check("single_no_terr", 32'(timeout_err), 32'd0);
        @(negedge clk);
        check("single_idle", 32'({busy, gnt0, done0}), 32'd0);

        // tx_done during START ignored; req/data changes during WAIT ignored
        apply_reset();
        req0 = 1'b1; data0 = 8'h3C;
        @(posedge clk); #1 tx_done = 1'b1;
        @(negedge clk);
        check("start_is_en", 32'(tx_en), 32'd1);
        @(posedge clk); #1 tx_done = 1'b0; req0 = 1'b0; data0 = 8'hFF;
        @(negedge clk);
        check("start_txdone_ign", 32'({busy, done0}), 32'b10);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("wait_data_hold", 32'(tx_data), 32'h3C);
        check("wait_gnt_hold", 32'(gnt0), 32'd1);
        @(posedge clk); #1 tx_done = 1'b1;
        @(posedge clk); #1 tx_done = 1'b0;
        @(negedge clk);
        check("wait_drop_done0", 32'(done0), 32'd1);
        check("wait_drop_data", 32'(tx_data), 32'h3C);

        // Both requesters held high for four transfers
        apply_reset();
        req0 = 1'b1; req1 = 1'b1; data0 = 8'h11; data1 = 8'h22;
        for (int t = 0; t < 4; t++) begin
            wait_en(1'b0, $sformatf("arb%0d", t), n);
            exp_data = exp_order[t] ? 8'h22 : 8'h11;
            check($sformatf("arb%0d_winner", t), 32'(gnt1), 32'(exp_order[t]));
            check($sformatf("arb%0d_onehot", t), 32'(gnt0 ^ gnt1), 32'd1);
            check($sformatf("arb%0d_data", t), 32'(tx_data), 32'(exp_data));
            @(posedge clk); #1 tx_done = 1'b1;
            @(posedge clk); #1 tx_done = 1'b0;
            @(negedge clk);
            check($sformatf("arb%0d_done", t), 32'({done1, done0}),
                  exp_order[t] ? 32'b10 : 32'b01);
            @(negedge clk);
            check($sformatf("arb%0d_idle_gap", t), 32'(busy), 32'd0);
        end

        // Watchdog with TIMEOUT_CYCLES=8 and no tx_done
        apply_reset();
        req1 = 1'b1; data1 = 8'h5A;
        wait_en(1'b1, "wd", n);
        done_at = -1; err_at = -1; done_cnt = 0; err_cnt = 0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1 req1 = 1'b0;
            @(negedge clk);
            if (w_done1) begin done_cnt++; if (done_at < 0) done_at = i; end
            if (w_timeout_err) begin err_cnt++; if (err_at < 0) err_at = i; end
        end
        check("wd_done_at", 32'(done_at), 32'd8);
        check("wd_err_at", 32'(err_at), 32'd8);
        check("wd_counts", 32'({done_cnt[7:0], err_cnt[7:0]}), 32'h0101);
        check("wd_back_idle", 32'({w_busy, w_gnt1}), 32'd0);

        // tx_done in the same cycle as the timeout: done wins, no timeout_err
        apply_reset();
        req1 = 1'b1; data1 = 8'h77;
        wait_en(1'b1, "wdtie", n);
        done_at = -1; err_cnt = 0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1 req1 = 1'b0; tx_done = (i == 7);
            @(negedge clk);
            if (w_done1 && done_at < 0) done_at = i;
            if (w_timeout_err) err_cnt++;
        end
        tx_done = 1'b0;
        check("wdtie_done_at", 32'(done_at), 32'd8);
        check("wdtie_no_err", 32'(err_cnt), 32'd0);

        // Reset asserted during WAIT, then a fresh request
        apply_reset();
        req0 = 1'b1; data0 = 8'h42;
        wait_en(1'b0, "midrst", n);
        @(posedge clk);
        @(posedge clk); #1 reset = 1'b0; req0 = 1'b0;
        #1;
        check("midrst_ctrl", 32'({gnt0, gnt1, done0, done1, tx_en, busy, timeout_err}), 32'd0);
        check("midrst_data", 32'(tx_data), 32'h00);
        any_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 2) reset = 1'b1;
            any_done = any_done | done0 | done1;
        end
        check("midrst_no_done", 32'(any_done), 32'd0);
        @(posedge clk); #1 req0 = 1'b1; data0 = 8'h99;
        wait_en(1'b0, "postrst", n);
        check("postrst_latency", 32'(n), 32'd2);
        check("postrst_data", 32'(tx_data), 32'h99);
        @(posedge clk); #1 tx_done = 1'b1; req0 = 1'b0;
        @(posedge clk); #1 tx_done = 1'b0;
        @(negedge clk);
        check("postrst_done0", 32'(done0), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 16'd50000, WAIT-state watchdog limit in clk cycles; legal range 2..65535.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 req0  input  1  requester 0 (fetch unit) wants one byte sent; level signal.
REQ-005 data0  input  8  requester 0 byte; valid while req0=1.
REQ-006 req1  input  1  requester 1 (bitty core) wants one byte sent; level signal.
REQ-007 data1  input  8  requester 1 byte; valid while req1=1.
REQ-008 gnt0, gnt1  output  1 each  requester owns the UART transmitter.
REQ-009 done0, done1  output  1 each  one-cycle pulse when that requester's byte is finished.
REQ-010 tx_en  output  1  one-cycle start pulse to the UART transmitter.
REQ-011 tx_data  output  8  registered byte to the UART transmitter.
REQ-012 tx_done  input  1  UART transmitter finished the current byte; pulse.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 timeout_err  output  1  one-cycle pulse when a transfer is aborted by the watchdog.

Function
REQ-015 The FSM SHALL have four states: IDLE, START, WAIT, DONE.
REQ-016 IDLE: when req0 or req1 is high, the FSM SHALL select a winner, latch the winner's data into tx_data, set that requester's gnt, and move to START on the next edge.
REQ-017 START: tx_en SHALL be 1 for exactly this one cycle; the next state SHALL be WAIT; the watchdog counter SHALL clear to 0.
REQ-018 WAIT: the watchdog counter SHALL increment every cycle. tx_done=1 SHALL move the FSM to DONE. If the counter reaches TIMEOUT_CYCLES-1 without tx_done, the FSM SHALL move to DONE and pulse timeout_err in that same transition cycle.
REQ-019 If tx_done and the timeout condition occur in the same cycle, tx_done SHALL win and timeout_err SHALL stay 0.
REQ-020 DONE: the granted requester's done pulse SHALL be 1 for this one cycle; gnt SHALL clear on exit; the next state SHALL be IDLE.
REQ-021 Latency: with the UART idle, the first req-high edge to tx_en SHALL be 2 cycles, and tx_done to done SHALL be 1 cycle.
REQ-022 gnt SHALL stay stable from START through DONE; req changes or data changes during that interval SHALL be ignored.
REQ-023 tx_done in IDLE, START or DONE SHALL be ignored.
REQ-024 A requester that still holds req in IDLE after its done pulse SHALL be treated as a new request; there SHALL be at least one IDLE cycle between transfers.
REQ-025 gnt0 and gnt1 SHALL never both be 1; tx_data SHALL hold its value outside the IDLE capture.
REQ-026 The watchdog counter SHALL be 16 bits wide and SHALL saturate, never wrap.

Reset
REQ-027 While reset=0, the FSM SHALL be in IDLE with gnt0, gnt1, done0, done1, tx_en, busy and timeout_err all 0, tx_data=8'h00, watchdog=0, and last-served pointer=1.
REQ-028 Reset asserted mid-transfer SHALL abort at once with no done pulse; the UART transmitter is reset by the same signal.

Configuration
REQ-029 When ARB_ROUND_ROBIN_EN is defined, and both req0 and req1 are high in IDLE, the grant SHALL go to the requester that was not served last; the last-served pointer SHALL update on entry to START.
REQ-030 When ARB_ROUND_ROBIN_EN is undefined, requester 0 SHALL always win a tie, and the pointer logic SHALL be omitted.

Verification
REQ-031 Only req0=1 with data0=8'hA5; tx_done pulsed 10 cycles after tx_en -> tx_en 2 cycles after req0, tx_data=8'hA5, gnt0 high throughout, done0 pulses 1 cycle after tx_done.
REQ-032 req0 and req1 held high together with data 8'h11 and 8'h22, four transfers, round robin on -> order after reset is 0,1,0,1; with round robin off -> order is 0,0,0,0.
REQ-033 TIMEOUT_CYCLES=8, req1=1, tx_done never arrives -> timeout_err and done1 each pulse once, exactly 8 cycles after tx_en; the FSM then returns to IDLE.
REQ-034 TIMEOUT_CYCLES=8, tx_done arrives in the same cycle as the timeout -> done pulses, timeout_err stays 0.
REQ-035 reset pulled low during WAIT -> all outputs are 0 in the same cycle, no done pulse; after release, a new req0 is served normally.
REQ-036 req0 dropped and data0 changed during WAIT -> tx_data is unchanged and done0 still pulses after tx_done.
